// File: rtl/demux2_stream.sv
// demux2_stream: registered 1-to-2 valid/ready stream demultiplexer.
//
// Each input word is routed to port A (i_SEL=0) or port B (i_SEL=1) and
// buffered in a DEPTH-entry FIFO per port. o_ready is derived only from
// i_SEL and the registered FIFO occupancy, so downstream ready never has a
// combinational path back to o_ready.
//
// Parameters:
//   NB     data width in bits
//   DEPTH  entries per output FIFO (power of 2, >= 2)
//
// Ports:
//   i_clock, i_reset          clock, asynchronous active-high reset
//   i_valid, i_SEL, i_data    input stream (i_SEL selects A=0 / B=1)
//   o_ready                   input accepted when i_valid & o_ready
//   o_valid_a/o_data_a/i_ready_a   port A output stream
//   o_valid_b/o_data_b/i_ready_b   port B output stream
//   o_cnt_a, o_cnt_b, i_cnt_clr    delivered-word counters (DEMUX2_CNT_EN only)
//
// Optional feature: define DEMUX2_CNT_EN to add saturating 16-bit counters of
// words delivered on each port, with a synchronous clear.

module demux2_stream_fifo #(
    parameter int unsigned NB    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,   // caller guarantees ~full
    input  logic          pop,    // caller guarantees valid
    input  logic [NB-1:0] din,
    output logic          valid,
    output logic          full,
    output logic [NB-1:0] dout
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [NB-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;

    // Storage carries no reset; dout is forced to zero while empty instead.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

    assign valid = (occ != '0);
    assign full  = (occ == (AW+1)'(DEPTH));
    assign dout  = valid ? mem[rd_ptr] : '0;
endmodule

module demux2_stream #(
    parameter int unsigned NB    = 32,
    parameter int unsigned DEPTH = 2
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_valid,
    input  logic          i_SEL,
    input  logic [NB-1:0] i_data,
    output logic          o_ready,
    output logic          o_valid_a,
    output logic [NB-1:0] o_data_a,
    input  logic          i_ready_a,
    output logic          o_valid_b,
    output logic [NB-1:0] o_data_b,
    input  logic          i_ready_b
`ifdef DEMUX2_CNT_EN
    ,
    output logic [15:0]   o_cnt_a,
    output logic [15:0]   o_cnt_b,
    input  logic          i_cnt_clr
`endif
);
    logic full_a;
    logic full_b;
    logic push_a;
    logic push_b;
    logic pop_a;
    logic pop_b;

    assign o_ready = i_SEL ? ~full_b : ~full_a;
    assign push_a  = i_valid & o_ready & ~i_SEL;
    assign push_b  = i_valid & o_ready &  i_SEL;
    assign pop_a   = o_valid_a & i_ready_a;
    assign pop_b   = o_valid_b & i_ready_b;

    demux2_stream_fifo #(.NB(NB), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (i_clock),
        .rst   (i_reset),
        .push  (push_a),
        .pop   (pop_a),
        .din   (i_data),
        .valid (o_valid_a),
        .full  (full_a),
        .dout  (o_data_a)
    );

    demux2_stream_fifo #(.NB(NB), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (i_clock),
        .rst   (i_reset),
        .push  (push_b),
        .pop   (pop_b),
        .din   (i_data),
        .valid (o_valid_b),
        .full  (full_b),
        .dout  (o_data_b)
    );

`ifdef DEMUX2_CNT_EN
    logic [15:0] cnt_a;
    logic [15:0] cnt_b;

    // Clear takes priority over a same-cycle pop; counts saturate at all-ones.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else if (i_cnt_clr) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (pop_a && cnt_a != '1) begin
                cnt_a <= cnt_a + 16'd1;
            end
            if (pop_b && cnt_b != '1) begin
                cnt_b <= cnt_b + 16'd1;
            end
        end
    end

    assign o_cnt_a = cnt_a;
    assign o_cnt_b = cnt_b;
`endif
endmodule

// File: tb/tb_demux2_stream.sv
// Directed/random testbench for demux2_stream (default DEPTH=2, NB=32).
module tb_demux2_stream;
    localparam int unsigned NB    = 32;
    localparam int unsigned DEPTH = 2;

    logic          i_clock = 1'b0;
    logic          i_reset;
    logic          i_valid;
    logic          i_SEL;
    logic [NB-1:0] i_data;
    logic          o_ready;
    logic          o_valid_a;
    logic [NB-1:0] o_data_a;
    logic          i_ready_a;
    logic          o_valid_b;
    logic [NB-1:0] o_data_b;
    logic          i_ready_b;
`ifdef DEMUX2_CNT_EN
    logic [15:0]   o_cnt_a;
    logic [15:0]   o_cnt_b;
    logic          i_cnt_clr;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 i_clock = ~i_clock;

    demux2_stream #(.NB(NB), .DEPTH(DEPTH)) dut (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_valid   (i_valid),
        .i_SEL     (i_SEL),
        .i_data    (i_data),
        .o_ready   (o_ready),
        .o_valid_a (o_valid_a),
        .o_data_a  (o_data_a),
        .i_ready_a (i_ready_a),
        .o_valid_b (o_valid_b),
        .o_data_b  (o_data_b),
        .i_ready_b (i_ready_b)
`ifdef DEMUX2_CNT_EN
        ,
        .o_cnt_a   (o_cnt_a),
        .o_cnt_b   (o_cnt_b),
        .i_cnt_clr (i_cnt_clr)
`endif
    );

    // Advance one cycle; inputs written after this take effect at the next edge.
    task automatic cyc();
        @(posedge i_clock);
        #1;
    endtask

    task automatic idle();
        i_valid   = 1'b0;
        i_SEL     = 1'b0;
        i_data    = '0;
        i_ready_a = 1'b0;
        i_ready_b = 1'b0;
`ifdef DEMUX2_CNT_EN
        i_cnt_clr = 1'b0;
`endif
    endtask

    task automatic test_reset();
        idle();
        i_reset = 1'b1;
        cyc();
        cyc();
        #1;
        n_cmp++; if (o_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_valid_a: got %b want 0", o_valid_a); end
        n_cmp++; if (o_valid_b !== 1'b0) begin n_bad++; $display("FAIL rst_valid_b: got %b want 0", o_valid_b); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", o_ready); end
        n_cmp++; if (o_data_a !== 32'h0) begin n_bad++; $display("FAIL rst_data_a: got %h want 0", o_data_a); end
        i_reset = 1'b0;
        cyc();
        // Fill A to full with no consumer, then reset mid-cycle.
        i_valid = 1'b1; i_SEL = 1'b0; i_data = 32'h11;
        cyc();
        i_data = 32'h22;
        cyc();
        i_valid = 1'b0;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL rst_pre_full: got %b want 0", o_ready); end
        n_cmp++; if (o_data_a !== 32'h11) begin n_bad++; $display("FAIL rst_pre_data: got %h want 11", o_data_a); end
        #1;
        i_reset = 1'b1;
        #1;
        n_cmp++; if (o_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_async_valid_a: got %b want 0", o_valid_a); end
        n_cmp++; if (o_data_a !== 32'h0) begin n_bad++; $display("FAIL rst_async_data_a: got %h want 0", o_data_a); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL rst_async_ready: got %b want 1", o_ready); end
`ifdef DEMUX2_CNT_EN
        n_cmp++; if (o_cnt_a !== 16'h0 || o_cnt_b !== 16'h0) begin n_bad++; $display("FAIL rst_cnt: got %h/%h want 0/0", o_cnt_a, o_cnt_b); end
`endif
        cyc();
        i_reset = 1'b0;
        cyc();
        n_cmp++; if (o_valid_a !== 1'b0) begin n_bad++; $display("FAIL rst_after_valid_a: got %b want 0", o_valid_a); end
    endtask

    task automatic test_route();
        idle();
        i_ready_a = 1'b1; i_ready_b = 1'b1;
        i_valid = 1'b1; i_SEL = 1'b0; i_data = 32'd1;
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL route_ready: got %b want 1", o_ready); end
        cyc();
        i_SEL = 1'b1; i_data = 32'd80;
        n_cmp++; if (o_valid_a !== 1'b1 || o_data_a !== 32'd1) begin n_bad++; $display("FAIL route_a: got %b/%0d want 1/1", o_valid_a, o_data_a); end
        n_cmp++; if (o_valid_b !== 1'b0) begin n_bad++; $display("FAIL route_b_early: got %b want 0", o_valid_b); end
        cyc();
        i_valid = 1'b0;
        n_cmp++; if (o_valid_a !== 1'b0) begin n_bad++; $display("FAIL route_a_pulse: got %b want 0", o_valid_a); end
        n_cmp++; if (o_valid_b !== 1'b1 || o_data_b !== 32'd80) begin n_bad++; $display("FAIL route_b: got %b/%0d want 1/80", o_valid_b, o_data_b); end
        cyc();
        n_cmp++; if (o_valid_b !== 1'b0) begin n_bad++; $display("FAIL route_b_pulse: got %b want 0", o_valid_b); end
    endtask

    task automatic test_backpressure();
        idle();
        i_valid = 1'b1; i_SEL = 1'b0; i_data = 32'hA1;
        cyc();
        i_data = 32'hA2;
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_occ1: got %b want 1", o_ready); end
        cyc();
        i_data = 32'hA3;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_full: got %b want 0", o_ready); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_cmp++; if (o_data_a !== 32'hA1 || o_valid_a !== 1'b1) begin n_bad++; $display("FAIL bp_stable: got %b/%h want 1/a1", o_valid_a, o_data_a); end
        end
        i_valid = 1'b0; i_SEL = 1'b1;
        #1;
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL bp_ready_selb: got %b want 1", o_ready); end
        i_SEL = 1'b0;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL bp_ready_sela: got %b want 0", o_ready); end
        i_ready_a = 1'b1;
        cyc();
        n_cmp++; if (o_valid_a !== 1'b1 || o_data_a !== 32'hA2) begin n_bad++; $display("FAIL bp_drain2: got %b/%h want 1/a2", o_valid_a, o_data_a); end
        cyc();
        n_cmp++; if (o_valid_a !== 1'b0) begin n_bad++; $display("FAIL bp_drain_empty: got %b want 0", o_valid_a); end
    endtask

    task automatic test_full_pushpop();
        idle();
        i_valid = 1'b1; i_SEL = 1'b0; i_data = 32'hC1;
        cyc();
        i_data = 32'hC2;
        cyc();
        i_data = 32'hC3; i_ready_a = 1'b1;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL fpp_refuse: got %b want 0", o_ready); end
        cyc();
        i_ready_a = 1'b0;
        #1;
        n_cmp++; if (o_valid_a !== 1'b1 || o_data_a !== 32'hC2) begin n_bad++; $display("FAIL fpp_popped: got %b/%h want 1/c2", o_valid_a, o_data_a); end
        n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL fpp_occ1_ready: got %b want 1", o_ready); end
        cyc();
        i_valid = 1'b0;
        #1;
        n_cmp++; if (o_ready !== 1'b0) begin n_bad++; $display("FAIL fpp_refull: got %b want 0", o_ready); end
        i_ready_a = 1'b1;
        cyc();
        n_cmp++; if (o_data_a !== 32'hC3 || o_valid_a !== 1'b1) begin n_bad++; $display("FAIL fpp_c3: got %b/%h want 1/c3", o_valid_a, o_data_a); end
        cyc();
        n_cmp++; if (o_valid_a !== 1'b0) begin n_bad++; $display("FAIL fpp_empty: got %b want 0", o_valid_a); end
    endtask

    task automatic test_interleave();
        logic [NB-1:0] qa[$];
        logic [NB-1:0] qb[$];
        logic          exp_ready;
        int            sent = 0;
        int            cycles = 0;
        idle();
        while ((sent < 100 || qa.size() != 0 || qb.size() != 0) && cycles < 3000) begin
            i_valid   = (sent < 100) && ($urandom_range(0, 3) != 0);
            i_SEL     = 1'($urandom_range(0, 1));
            i_data    = $urandom;
            i_ready_a = (sent >= 100) || ($urandom_range(0, 2) != 0);
            i_ready_b = (sent >= 100) || ($urandom_range(0, 2) != 0);
            #1;
            exp_ready = i_SEL ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
            n_cmp++; if (o_ready !== exp_ready) begin n_bad++; $display("FAIL il_ready: got %b want %b", o_ready, exp_ready); end
            n_cmp++; if (o_valid_a !== (qa.size() != 0)) begin n_bad++; $display("FAIL il_valid_a: got %b want %b", o_valid_a, qa.size() != 0); end
            n_cmp++; if (o_valid_b !== (qb.size() != 0)) begin n_bad++; $display("FAIL il_valid_b: got %b want %b", o_valid_b, qb.size() != 0); end
            if (qa.size() != 0) begin
                n_cmp++; if (o_data_a !== qa[0]) begin n_bad++; $display("FAIL il_data_a: got %h want %h", o_data_a, qa[0]); end
                if (i_ready_a) void'(qa.pop_front());
            end
            if (qb.size() != 0) begin
                n_cmp++; if (o_data_b !== qb[0]) begin n_bad++; $display("FAIL il_data_b: got %h want %h", o_data_b, qb[0]); end
                if (i_ready_b) void'(qb.pop_front());
            end
            if (i_valid && exp_ready) begin
                if (i_SEL) qb.push_back(i_data);
                else       qa.push_back(i_data);
                sent++;
            end
            cyc();
            cycles++;
        end
        n_cmp++; if (cycles >= 3000) begin n_bad++; $display("FAIL il_timeout: got %0d cycles want < 3000", cycles); end
        idle();
        #1;
        n_cmp++; if (o_valid_a !== 1'b0 || o_valid_b !== 1'b0) begin n_bad++; $display("FAIL il_end_empty: got %b/%b want 0/0", o_valid_a, o_valid_b); end
    endtask

`ifdef DEMUX2_CNT_EN
    task automatic test_counters();
        idle();
        i_cnt_clr = 1'b1;
        cyc();
        i_cnt_clr = 1'b0;
        n_cmp++; if (o_cnt_a !== 16'd0 || o_cnt_b !== 16'd0) begin n_bad++; $display("FAIL cnt_clear: got %0d/%0d want 0/0", o_cnt_a, o_cnt_b); end
        i_ready_a = 1'b1; i_ready_b = 1'b1; i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_SEL  = (i >= 5);
            i_data = 32'(i + 100);
            cyc();
        end
        i_valid = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (o_cnt_a !== 16'd5) begin n_bad++; $display("FAIL cnt_a5: got %0d want 5", o_cnt_a); end
        n_cmp++; if (o_cnt_b !== 16'd3) begin n_bad++; $display("FAIL cnt_b3: got %0d want 3", o_cnt_b); end
        i_valid = 1'b1; i_SEL = 1'b0;
        cyc();
        i_valid = 1'b0; i_cnt_clr = 1'b1;
        cyc();
        i_cnt_clr = 1'b0;
        n_cmp++; if (o_cnt_a !== 16'd0 || o_cnt_b !== 16'd0) begin n_bad++; $display("FAIL cnt_clr_wins: got %0d/%0d want 0/0", o_cnt_a, o_cnt_b); end
        force dut.cnt_a = 16'hFFFF;
        #1;
        release dut.cnt_a;
        i_valid = 1'b1; i_SEL = 1'b0;
        cyc();
        i_valid = 1'b0;
        cyc();
        cyc();
        n_cmp++; if (o_cnt_a !== 16'hFFFF) begin n_bad++; $display("FAIL cnt_sat: got %h want ffff", o_cnt_a); end
    endtask
`endif

    initial begin
        i_reset = 1'b1;
        idle();
        test_reset();
        test_route();
        test_backpressure();
        test_full_pushpop();
        test_interleave();
`ifdef DEMUX2_CNT_EN
        test_counters();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
